// File: rtl/cpu_clk_pkg.sv
// rtl/cpu_clk_pkg.sv - shared speed codes, FSM states and default rates for the CPU clock-enable controller
package cpu_clk_pkg;

    localparam logic [1:0] SPD_477  = 2'd0;
    localparam logic [1:0] SPD_716  = 2'd1;
    localparam logic [1:0] SPD_954  = 2'd2;
    localparam logic [1:0] SPD_RSVD = 2'd3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HELD  = 2'd2
    } clk_state_e;

    localparam int unsigned DEF_CLK_IN = 25000000;
    localparam int unsigned DEF_RATE0  = 4772727;
    localparam int unsigned DEF_RATE1  = 7159090;
    localparam int unsigned DEF_RATE2  = 9545454;

endpackage

// File: rtl/frac_accum.sv
// rtl/frac_accum.sv - fractional-N accumulator producing a registered 1-cycle pulse per CLK_IN overflow
module frac_accum #(
    parameter int unsigned CLK_IN = 25000000,
    parameter int unsigned ACC_W  = 26
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [ACC_W-1:0] iInc,
    input  logic             iStep,
    input  logic             iClear,
    output logic             oPulse,
    output logic [ACC_W-1:0] oAcc
);

    localparam logic [ACC_W:0] LIMIT = (ACC_W+1)'(CLK_IN);

    // One extra bit so acc+inc can never wrap before the compare.
    logic [ACC_W:0] sum;
    assign sum = {1'b0, oAcc} + {1'b0, iInc};

    always_ff @(posedge iClk) begin
        if (iRst || iClear) begin
            oAcc   <= '0;
            oPulse <= 1'b0;
        end else if (iStep) begin
            if (sum >= LIMIT) begin
                oAcc   <= ACC_W'(sum - LIMIT);
                oPulse <= 1'b1;
            end else begin
                oAcc   <= sum[ACC_W-1:0];
                oPulse <= 1'b0;
            end
        end else begin
            oPulse <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// rtl/cpu_clk_ctrl.sv - CPU clock-enable speed/hold controller: boundary-aligned speed changes and bus-hold freeze
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int unsigned CLK_IN      = DEF_CLK_IN,
    parameter int unsigned RATE0       = DEF_RATE0,
    parameter int unsigned RATE1       = DEF_RATE1,
    parameter int unsigned RATE2       = DEF_RATE2,
    parameter int unsigned RESET_SPEED = 0,
    parameter int unsigned ACC_W       = 26
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iSpeedWr,
    input  logic [1:0] iSpeedSel,
    input  logic       iHold,
    output logic       oClkEn,
    output logic       oHoldAck,
    output logic [1:0] oSpeed,
    output logic       oBusy
);

    clk_state_e       state, stateNext;
    logic             pendValid;
    logic [1:0]       pendCode;
    logic             step, apply;
    logic [ACC_W-1:0] inc, accVal;

    always_comb begin
        inc = ACC_W'(RATE0);
        case (oSpeed)
            SPD_716: inc = ACC_W'(RATE1);
            SPD_954: inc = ACC_W'(RATE2);
            default: inc = ACC_W'(RATE0);
        endcase
    end

    // Speed changes land only right after a pulse (or on hold release) so no CPU period is cut short.
    always_comb begin
        stateNext = state;
        step      = 1'b0;
        apply     = 1'b0;
        case (state)
            RUN: begin
                if (oClkEn && pendValid) apply = 1'b1;
                else                     step  = 1'b1;
                if (iHold) stateNext = DRAIN;
            end
            DRAIN: begin
                if (!iHold) begin
                    stateNext = RUN;
                    step      = 1'b1;
                end else if (oClkEn) begin
                    stateNext = HELD;
                end else begin
                    step = 1'b1;
                end
            end
            HELD: begin
                if (!iHold) begin
                    stateNext = RUN;
                    apply     = pendValid;
                end
            end
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= RUN;
            pendValid <= 1'b0;
            pendCode  <= 2'(RESET_SPEED);
            oSpeed    <= 2'(RESET_SPEED);
        end else begin
            state <= stateNext;
            if (apply) begin
                oSpeed    <= pendCode;
                pendValid <= 1'b0;
            end
            if (iSpeedWr && (iSpeedSel != SPD_RSVD)) begin
                pendValid <= 1'b1;
                pendCode  <= iSpeedSel;
            end
        end
    end

    assign oBusy    = pendValid;
    assign oHoldAck = (state == HELD);

    frac_accum #(
        .CLK_IN (CLK_IN),
        .ACC_W  (ACC_W)
    ) uAccum (
        .iClk   (iClk),
        .iRst   (iRst),
        .iInc   (inc),
        .iStep  (step),
        .iClear (apply),
        .oPulse (oClkEn),
        .oAcc   (accVal)
    );

    // Residue must always sit below one full CPU period.
    always_ff @(posedge iClk) begin
        if (!iRst) assert ({1'b0, accVal} < (ACC_W+1)'(CLK_IN));
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb/tb_cpu_clk_ctrl.sv - self-checking bench for cpu_clk_ctrl against an arithmetic reference model
module tb_cpu_clk_ctrl;

    localparam int C  = 10;
    localparam int R0 = 3;
    localparam int R1 = 4;
    localparam int R2 = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       en, ack, busy;
    logic [1:0] spd;

    int vectors = 0;
    int miscompares = 0;

    int mSteps, mSpeed, mPendCode;
    bit mPendV, mHeld, mDrain, mEn;

    cpu_clk_ctrl #(
        .CLK_IN(C), .RATE0(R0), .RATE1(R1), .RATE2(R2), .RESET_SPEED(0), .ACC_W(8)
    ) dut (
        .iClk(clk), .iRst(rst), .iSpeedWr(wr), .iSpeedSel(sel), .iHold(hold),
        .oClkEn(en), .oHoldAck(ack), .oSpeed(spd), .oBusy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int rateOf(input int s);
        case (s)
            1:       return R1;
            2:       return R2;
            default: return R0;
        endcase
    endfunction

    // Residue after n steps at rate r since the last clear is simply n*r mod C.
    function automatic int modelAcc();
        return (mSteps * rateOf(mSpeed)) % C;
    endfunction

    task automatic modelEdge();
        bit doStep = 1'b0;
        bit doApply = 1'b0;
        int r;
        if (rst) begin
            mSteps = 0; mSpeed = 0; mPendV = 0; mPendCode = 0;
            mHeld = 0; mDrain = 0; mEn = 0;
            return;
        end
        if (mHeld) begin
            if (!hold) begin mHeld = 0; doApply = mPendV; end
        end else if (mDrain) begin
            if (!hold)     begin mDrain = 0; doStep = 1; end
            else if (mEn)  begin mDrain = 0; mHeld = 1; end
            else           doStep = 1;
        end else begin
            if (mEn && mPendV) doApply = 1;
            else               doStep = 1;
            if (hold) mDrain = 1;
        end
        mEn = 0;
        if (doApply) begin mSpeed = mPendCode; mPendV = 0; mSteps = 0; end
        if (doStep) begin
            r = rateOf(mSpeed);
            mSteps++;
            mEn = ((mSteps * r) / C) != (((mSteps - 1) * r) / C);
        end
        if (wr && sel != 2'd3) begin mPendV = 1; mPendCode = int'(sel); end
    endtask

    task automatic cycle();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic waitPulse(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            cycle();
            if (en) begin seen = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1; hold = 0; wr = 0;
        cycle(); cycle();
        vectors++;
        if ({en, ack, busy, spd} !== 5'b0 || dut.uAccum.oAcc !== 8'd0) begin
            miscompares++;
            $display("FAIL reset: en=%b ack=%b busy=%b spd=%0d acc=%0d, want all 0", en, ack, busy, spd, dut.uAccum.oAcc);
        end
        rst = 0;
    endtask

    task automatic test_rate();
        int pulses = 0, last = -1, first = -1;
        bit prev = 0, gapOk = 1, widthOk = 1;
        for (int i = 1; i <= 100; i++) begin
            cycle();
            if (en) begin
                pulses++;
                if (first < 0) first = i;
                if (prev) widthOk = 0;
                if (last >= 0 && (i - last < 3 || i - last > 4)) gapOk = 0;
                last = i;
            end
            prev = en;
            vectors++;
            if (en !== mEn) begin miscompares++; $display("FAIL rate_en cyc %0d: got %b want %b", i, en, mEn); end
        end
        vectors++;
        if (pulses != 30) begin miscompares++; $display("FAIL rate_count: got %0d want 30", pulses); end
        vectors++;
        if (first != 4) begin miscompares++; $display("FAIL first_pulse: got cycle %0d want 4", first); end
        vectors++;
        if (!widthOk || !gapOk) begin miscompares++; $display("FAIL rate_shape: width_ok=%b gap_ok=%b want 1 1", widthOk, gapOk); end
    endtask

    task automatic test_switch();
        bit seen;
        cycle();
        wr = 1; sel = 2'd2; cycle(); wr = 0;
        vectors++;
        if (busy !== 1'b1 || spd !== 2'd0) begin miscompares++; $display("FAIL switch_pending: busy=%b spd=%0d want 1 0", busy, spd); end
        waitPulse(10, seen);
        vectors++;
        if (!seen || busy !== 1'b1) begin miscompares++; $display("FAIL switch_wait: pulse=%b busy=%b want 1 1", seen, busy); end
        cycle();
        vectors++;
        if (spd !== 2'd2 || busy !== 1'b0 || en !== 1'b0 || dut.uAccum.oAcc !== 8'd0) begin
            miscompares++;
            $display("FAIL switch_apply: spd=%0d busy=%b en=%b acc=%0d want 2 0 0 0", spd, busy, en, dut.uAccum.oAcc);
        end
        for (int k = 1; k <= 6; k++) begin
            cycle();
            vectors++;
            if (en !== ((k % 2) == 0)) begin miscompares++; $display("FAIL switch_spacing k=%0d: got %b want %b", k, en, (k % 2) == 0); end
        end
    endtask

    task automatic test_collision();
        bit seen, sawOne = 0;
        wr = 1; sel = 2'd0; cycle(); wr = 0;
        waitPulse(10, seen); cycle();
        vectors++;
        if (!seen || spd !== 2'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL collision_setup: spd=%0d busy=%b want 0 0", spd, busy); end
        wr = 1; sel = 2'd1; cycle();
        sel = 2'd2; cycle(); wr = 0;
        for (int i = 0; i < 12 && busy; i++) begin
            cycle();
            if (spd == 2'd1) sawOne = 1;
        end
        vectors++;
        if (sawOne || spd !== 2'd2 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL collision: spd=%0d busy=%b saw_code1=%b want 2 0 0", spd, busy, sawOne);
        end
        wr = 1; sel = 2'd3; cycle(); wr = 0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (busy !== 1'b0 || spd !== 2'd2) begin miscompares++; $display("FAIL reserved_write: busy=%b spd=%0d want 0 2", busy, spd); end
            cycle();
        end
    endtask

    task automatic test_hold();
        bit seen, gotAck = 0;
        int pulses = 0, frozen, expK, gotK = -1;
        waitPulse(10, seen);
        cycle();
        hold = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (en) pulses++;
            if (ack) begin gotAck = 1; break; end
        end
        vectors++;
        if (!gotAck || pulses != 1) begin miscompares++; $display("FAIL hold_drain: ack=%b pulses=%0d want 1 1", gotAck, pulses); end
        frozen = modelAcc();
        for (int i = 0; i < 50; i++) begin
            cycle();
            vectors++;
            if (en !== 1'b0 || ack !== 1'b1 || dut.uAccum.oAcc !== 8'(frozen)) begin
                miscompares++;
                $display("FAIL hold_frozen cyc %0d: en=%b ack=%b acc=%0d want 0 1 %0d", i, en, ack, dut.uAccum.oAcc, frozen);
            end
        end
        hold = 0; cycle();
        vectors++;
        if (ack !== 1'b0 || dut.uAccum.oAcc !== 8'(frozen)) begin miscompares++; $display("FAIL hold_release: ack=%b acc=%0d want 0 %0d", ack, dut.uAccum.oAcc, frozen); end
        expK = (C - frozen + R2 - 1) / R2;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (en) begin gotK = i; break; end
        end
        vectors++;
        if (gotK != expK) begin miscompares++; $display("FAIL hold_resume: next pulse after %0d cycles, want %0d", gotK, expK); end
    endtask

    task automatic test_hold_pending();
        bit gotAck = 0;
        hold = 1;
        for (int i = 0; i < 20 && !gotAck; i++) begin cycle(); gotAck = ack; end
        wr = 1; sel = 2'd1; cycle(); wr = 0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (!gotAck || busy !== 1'b1 || ack !== 1'b1 || spd !== 2'd2) begin
                miscompares++;
                $display("FAIL held_pending: ack=%b busy=%b spd=%0d want 1 1 2", ack, busy, spd);
            end
            cycle();
        end
        hold = 0; cycle();
        vectors++;
        if (ack !== 1'b0 || spd !== 2'd1 || busy !== 1'b0 || dut.uAccum.oAcc !== 8'd0) begin
            miscompares++;
            $display("FAIL held_apply: ack=%b spd=%0d busy=%b acc=%0d want 0 1 0 0", ack, spd, busy, dut.uAccum.oAcc);
        end
    endtask

    task automatic test_reset_mid_held();
        bit gotAck = 0;
        hold = 1;
        for (int i = 0; i < 20 && !gotAck; i++) begin cycle(); gotAck = ack; end
        wr = 1; sel = 2'd2; cycle(); wr = 0;
        rst = 1; cycle();
        vectors++;
        if (!gotAck || {en, ack, busy, spd} !== 5'b0 || dut.uAccum.oAcc !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_held: held=%b en=%b ack=%b busy=%b spd=%0d acc=%0d want 1 0 0 0 0 0", gotAck, en, ack, busy, spd, dut.uAccum.oAcc);
        end
        rst = 0; hold = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) hold = ~hold;
            wr  = ($urandom_range(0, 9) == 0);
            sel = 2'($urandom_range(0, 3));
            cycle();
            vectors++;
            if ({en, ack, busy, spd} !== {mEn, mHeld, mPendV, 2'(mSpeed)} || dut.uAccum.oAcc !== 8'(modelAcc())) begin
                miscompares++;
                $display("FAIL random cyc %0d: en=%b ack=%b busy=%b spd=%0d acc=%0d want %b %b %b %0d %0d",
                         i, en, ack, busy, spd, dut.uAccum.oAcc, mEn, mHeld, mPendV, mSpeed, modelAcc());
            end
        end
        wr = 0; hold = 0;
    endtask

    initial begin
        test_reset();
        test_rate();
        test_switch();
        test_collision();
        test_hold();
        test_hold_pending();
        test_reset_mid_held();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
Speed and hold controller for the CPU clock-enable in the XT core. It contains a fractional-N accumulator that derives a 1-cycle-wide CPU clock-enable from iClk. It schedules runtime speed changes (4.77 MHz / 7.16 MHz / 9.54 MHz turbo) only at enable boundaries, so no CPU period is ever short. It freezes the enable for bus-hold requesters (DMA, video) after the in-flight CPU period completes.

Parameters:
- CLK_IN, 25000000: iClk frequency, Hz.
- RATE0, 4772727: speed code 0 rate, Hz.
- RATE1, 7159090: speed code 1 rate, Hz.
- RATE2, 9545454: speed code 2 rate, Hz.
- RESET_SPEED, 0: speed code active after reset.
- ACC_W, 26: accumulator width. Must satisfy 2^ACC_W > CLK_IN + max(RATEn).

Ports:
- iClk  in  1  system clock, all logic on posedge.
- iRst  in  1  synchronous, active-high reset.
- iSpeedWr  in  1  1-cycle strobe; latch iSpeedSel as pending speed.
- iSpeedSel  in  2  requested speed code: 0/1/2. Code 3 is reserved; a write of 3 is ignored.
- iHold  in  1  level; request that CPU enables stop.
- oClkEn  out  1  CPU clock-enable, 1 iClk cycle wide, registered.
- oHoldAck  out  1  high while enables are frozen (state HELD).
- oSpeed  out  2  currently active speed code.
- oBusy  out  1  a speed change is pending (latched, not yet applied).

Behaviour:
- Reset (iRst=1 at posedge): acc=0; oClkEn=0; oHoldAck=0; oBusy=0; oSpeed=RESET_SPEED; state=RUN; pending cleared.
- Accumulator step, used in RUN and DRAIN. inc = RATE of the active speed code.
  - If acc+inc >= CLK_IN: acc <= acc+inc-CLK_IN and oClkEn <= 1.
  - Else: acc <= acc+inc and oClkEn <= 0.
  - Sum is computed at ACC_W+1 bits; no wrap is permitted.
- Long-run pulse count over N cycles = floor(N*RATE/CLK_IN), ±1.
- Speed write:
  - iSpeedWr with a valid code sets pending=code and oBusy=1.
  - Later writes before application overwrite pending; last write wins.
  - A write of code 3 changes nothing.
  - Writing the code that is already active still goes pending and is applied.
- Speed apply, in RUN: on the cycle after oClkEn=1, with pending valid:
  - oSpeed <= pending, acc <= 0, oBusy <= 0.
  - No step occurs in the apply cycle; oClkEn=0 in it.
  - New-rate stepping starts the next cycle.
  - A write landing in the same cycle oClkEn is high waits for the next pulse.
- FSM:
  - RUN -> DRAIN: iHold=1. Stepping continues.
  - DRAIN -> HELD: on the cycle after the next oClkEn=1 pulse. That pulse completes the current CPU period and is emitted normally.
  - HELD: acc frozen; oClkEn=0; oHoldAck=1 (registered, asserted on entry).
  - HELD -> RUN: iHold=0. oHoldAck drops the same edge. Stepping resumes the next cycle from the frozen acc.
  - If pending is valid on HELD exit, the apply rule runs as the first RUN cycle (acc <= 0, oSpeed updated).
  - DRAIN with iHold dropped before the pulse: return to RUN with no gap in stepping.
  - iSpeedWr is accepted in every state.
- Reset mid-DRAIN/HELD: immediate return to reset values; pending is discarded.
- Latency: the first oClkEn after reset occurs when acc+inc first reaches CLK_IN. For example, with CLK_IN=10 and RATE0=3, oClkEn is high in the 4th cycle after iRst deasserts.

Decomposition:
- Package cpu_clk_pkg holds:
  - speed code constants SPD_477, SPD_716, SPD_954, SPD_RSVD;
  - state encoding RUN, DRAIN, HELD;
  - the default rate constants.
- Sub-module frac_accum (params CLK_IN, ACC_W):
  - inputs iInc, iStep, iClear;
  - outputs oPulse and the accumulator value.
  - It implements the step and clear rules only.
- cpu_clk_ctrl owns the FSM, pending register, rate mux and hold handshake.

Test Plan:
- Rate check: CLK_IN=10, RATE0=3; iRst for 2 cycles, then run 100 cycles -> exactly 30 oClkEn pulses; every pulse 1 cycle wide; gaps of 3 or 4 cycles.
- Switch at boundary: write 2 (RATE2=5) mid-period -> oBusy=1 until the next pulse; then oSpeed=2, oBusy=0, acc=0; subsequent pulses every 2 cycles.
- Write collision: write 1 then 2 in consecutive cycles -> only code 2 is applied. A write of 3 leaves oBusy=0 and oSpeed unchanged.
- Hold: assert iHold 1 cycle after a pulse -> exactly one more pulse, then oHoldAck=1 with no oClkEn for 50 cycles. Release -> oHoldAck=0 the same edge; the next pulse spacing is consistent with the frozen acc.
- Hold plus pending: write 1 while HELD -> oBusy stays 1. On release, the first RUN cycle sets oSpeed=1 and acc=0.
- Reset mid-HELD with pending: assert iRst -> all outputs return to reset values; oSpeed=RESET_SPEED; oBusy=0.
